mem_stage: RTL and testbench

Memory-access stage that sits directly downstream of the execute block. It consumes the ALU result, the second register operand and the memory/writeback control bits. It performs word loads and stores against an internal synchronous data RAM, then registers a writeback bundle (data, destination register, write enable) for the register file. Loads take two cycles, and the stage stalls upstream for the extra cycle.

---
 rtl/mem_stage_if.sv | 44 ++++
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module   : mem_stage_if
// Purpose  : Bundle between the execute block, the memory-access stage and the
//            register-file writeback port.
// Ports    : master - execute side: drives the execute bundle and the control
//                     bits, observes stall and the writeback bundle.
//            slave  - memory stage: consumes the execute bundle and drives
//                     stall and the writeback bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  // Execute bundle
  logic        in_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_wrdata;
  logic [4:0]  ex_wreg;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  // Back-pressure and writeback bundle
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_RegWrite;
  logic        misaligned;

  modport master (
    output in_valid, ex_result, ex_wrdata, ex_wreg,
           MemRead, MemWrite, MemtoReg, RegWrite,
    input  stall, wb_valid, wb_data, wb_reg, wb_RegWrite, misaligned
  );

  modport slave (
    input  in_valid, ex_result, ex_wrdata, ex_wreg,
           MemRead, MemWrite, MemtoReg, RegWrite,
    output stall, wb_valid, wb_data, wb_reg, wb_RegWrite, misaligned
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Word loads/stores against an
//            internal synchronous RAM of 2^ADDR_W x 32 bits, followed by a
//            registered writeback bundle. ALU ops and stores complete in one
//            cycle; loads take two and stall upstream for the extra cycle.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous, active-low reset
//            bus  - mem_stage_if.slave (execute bundle in, stall and
//                   writeback bundle out)
// Params   : ADDR_W - word-address width (RAM depth 2^ADDR_W)
// Macros   : MEM_INIT_EN - when defined, a CLEAR state zeroes every RAM word
//                          after reset, holding stall high for 2^ADDR_W cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              state_q;

  // Writeback registers
  logic                wb_valid_q;
  logic [31:0]         wb_data_q;
  logic [4:0]          wb_reg_q;
  logic                wb_regwrite_q;
  logic                misaligned_q;

  // Copy of the load bundle held across the LOAD cycle
  logic [4:0]          ld_reg_q;
  logic                ld_regwrite_q;
  logic                ld_memtoreg_q;
  logic [31:0]         ld_result_q;

  // Data RAM and its registered read port
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         ram_rd_q;

  // Decode of the incoming bundle
  logic [ADDR_W-1:0]   w_addr;
  logic                w_stall;
  logic                w_accept;
  logic                w_misal;
  logic                w_store;
  logic                w_load;

  // RAM write port
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_waddr;
  logic [31:0]         w_ram_wdata;

  // Byte address -> word address; upper bits drop out so accesses wrap.
  assign w_addr   = bus.ex_result[ADDR_W+1:2];
  assign w_stall  = (state_q == S_LOAD) || (state_q == S_CLEAR);
  assign w_accept = bus.in_valid & ~w_stall;
  assign w_misal  = (bus.MemRead | bus.MemWrite) & (bus.ex_result[1:0] != 2'b00);
  // MemWrite wins when both control bits are set.
  assign w_store  = w_accept & bus.MemWrite & ~w_misal;
  assign w_load   = w_accept & bus.MemRead & ~bus.MemWrite & ~w_misal;

`ifdef MEM_INIT_EN
  logic [ADDR_W-1:0]   clr_cnt_q;

  // The sweep owns the write port while clearing; no accepts occur then.
  assign w_ram_we    = rst & ((state_q == S_CLEAR) | w_store);
  assign w_ram_waddr = (state_q == S_CLEAR) ? clr_cnt_q : w_addr;
  assign w_ram_wdata = (state_q == S_CLEAR) ? 32'd0 : bus.ex_wrdata;
`else
  // Gating with rst keeps the RAM untouched while reset is held.
  assign w_ram_we    = rst & w_store;
  assign w_ram_waddr = w_addr;
  assign w_ram_wdata = bus.ex_wrdata;
`endif

  // --------------------------------------------------------------------------
  // Synchronous RAM: contents are never reset. A store lands at its accept
  // edge, so a load accepted on the following edge reads the new data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      mem_q[w_ram_waddr] <= w_ram_wdata;
    end
    if (w_load) begin
      ram_rd_q <= mem_q[w_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Stage control and writeback registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef MEM_INIT_EN
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
`else
      state_q       <= S_IDLE;
`endif
      wb_valid_q    <= 1'b0;
      wb_data_q     <= 32'd0;
      wb_reg_q      <= 5'd0;
      wb_regwrite_q <= 1'b0;
      misaligned_q  <= 1'b0;
      ld_reg_q      <= 5'd0;
      ld_regwrite_q <= 1'b0;
      ld_memtoreg_q <= 1'b0;
      ld_result_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Default: nothing retires; data and register number hold.
          wb_valid_q    <= 1'b0;
          wb_regwrite_q <= 1'b0;
          misaligned_q  <= 1'b0;
          if (w_accept) begin
            if (w_misal) begin
              // Faulted access retires immediately with a zeroed, non-writing bundle.
              wb_valid_q    <= 1'b1;
              wb_data_q     <= 32'd0;
              wb_reg_q      <= bus.ex_wreg;
              wb_regwrite_q <= 1'b0;
              misaligned_q  <= 1'b1;
            end else if (bus.MemWrite) begin
              wb_valid_q    <= 1'b1;
              wb_data_q     <= bus.ex_result;
              wb_reg_q      <= bus.ex_wreg;
              wb_regwrite_q <= 1'b0;
            end else if (bus.MemRead) begin
              // RAM samples the address this edge; finish in LOAD.
              ld_reg_q      <= bus.ex_wreg;
              ld_regwrite_q <= bus.RegWrite;
              ld_memtoreg_q <= bus.MemtoReg;
              ld_result_q   <= bus.ex_result;
              state_q       <= S_LOAD;
            end else begin
              wb_valid_q    <= 1'b1;
              wb_data_q     <= bus.ex_result;
              wb_reg_q      <= bus.ex_wreg;
              wb_regwrite_q <= bus.RegWrite;
            end
          end
        end

        S_LOAD: begin
          wb_valid_q    <= 1'b1;
          wb_data_q     <= ld_memtoreg_q ? ram_rd_q : ld_result_q;
          wb_reg_q      <= ld_reg_q;
          wb_regwrite_q <= ld_regwrite_q;
          misaligned_q  <= 1'b0;
          state_q       <= S_IDLE;
        end

`ifdef MEM_INIT_EN
        S_CLEAR: begin
          wb_valid_q    <= 1'b0;
          wb_regwrite_q <= 1'b0;
          misaligned_q  <= 1'b0;
          clr_cnt_q     <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= S_IDLE;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall       = w_stall;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_RegWrite = wb_regwrite_q;
  assign bus.misaligned  = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage: reset values, ALU
//            passthrough, store/load with stall, misaligned accesses, address
//            wrap-around, combined read+write, and reset during a load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(.ADDR_W(8)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] wd,
                       input logic [4:0] wreg, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    bus.in_valid  = v;
    bus.ex_result = res;
    bus.ex_wrdata = wd;
    bus.ex_wreg   = wreg;
    bus.MemRead   = mr;
    bus.MemWrite  = mw;
    bus.MemtoReg  = m2r;
    bus.RegWrite  = rw;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_ready();
`ifdef MEM_INIT_EN
    for (int i = 0; i < 400 && bus.stall; i++) step();
    chk("init_sweep_done", {31'd0, bus.stall}, 32'd0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- Reset with arbitrary inputs ----------------
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); step(); step();
    chk("rst_wb_valid",    {31'd0, bus.wb_valid},    32'd0);
    chk("rst_wb_data",     bus.wb_data,              32'd0);
    chk("rst_wb_reg",      {27'd0, bus.wb_reg},      32'd0);
    chk("rst_wb_RegWrite", {31'd0, bus.wb_RegWrite}, 32'd0);
    chk("rst_misaligned",  {31'd0, bus.misaligned},  32'd0);
`ifdef MEM_INIT_EN
    chk("rst_stall",       {31'd0, bus.stall},       32'd1);
`else
    chk("rst_stall",       {31'd0, bus.stall},       32'd0);
`endif
    idle();
    step();
    rst_n = 1'b1;
    wait_ready();

    // ---------------- ALU passthrough ----------------
    drive(1'b1, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("alu_wb_valid",    {31'd0, bus.wb_valid},    32'd1);
    chk("alu_wb_data",     bus.wb_data,              32'h0000_1234);
    chk("alu_wb_reg",      {27'd0, bus.wb_reg},      32'd5);
    chk("alu_wb_RegWrite", {31'd0, bus.wb_RegWrite}, 32'd1);
    chk("alu_misaligned",  {31'd0, bus.misaligned},  32'd0);
    idle();
    step();
    chk("idle_wb_valid",   {31'd0, bus.wb_valid},    32'd0);
    chk("idle_wb_data",    bus.wb_data,              32'h0000_1234);

    // ---------------- Store 0xDEADBEEF @0x10, then load it back ----------------
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("st_wb_valid",     {31'd0, bus.wb_valid},    32'd1);
    chk("st_wb_RegWrite",  {31'd0, bus.wb_RegWrite}, 32'd0);
    chk("st_stall",        {31'd0, bus.stall},       32'd0);
    drive(1'b1, 32'h0000_0010, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("ld_stall",        {31'd0, bus.stall},       32'd1);
    chk("ld_wait_valid",   {31'd0, bus.wb_valid},    32'd0);
    // Offered during the stall: must be ignored.
    drive(1'b1, 32'h0000_9999, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("ld_wb_valid",     {31'd0, bus.wb_valid},    32'd1);
    chk("ld_wb_data",      bus.wb_data,              32'hDEAD_BEEF);
    chk("ld_wb_reg",       {27'd0, bus.wb_reg},      32'd7);
    chk("ld_wb_RegWrite",  {31'd0, bus.wb_RegWrite}, 32'd1);
    chk("ld_stall_done",   {31'd0, bus.stall},       32'd0);
    idle();
    step();
    chk("stalled_ignored", {31'd0, bus.wb_valid},    32'd0);

    // ---------------- Misaligned load and store ----------------
    drive(1'b1, 32'h0000_0013, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("mis_ld_flag",     {31'd0, bus.misaligned},  32'd1);
    chk("mis_ld_valid",    {31'd0, bus.wb_valid},    32'd1);
    chk("mis_ld_RegWrite", {31'd0, bus.wb_RegWrite}, 32'd0);
    chk("mis_ld_data",     bus.wb_data,              32'd0);
    chk("mis_ld_stall",    {31'd0, bus.stall},       32'd0);
    drive(1'b1, 32'h0000_0012, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("mis_st_flag",     {31'd0, bus.misaligned},  32'd1);
    drive(1'b1, 32'h0000_0010, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("mis_flag_clear",  {31'd0, bus.misaligned},  32'd0);
    idle();
    step();
    chk("mis_st_no_write", bus.wb_data,              32'hDEAD_BEEF);

    // ---------------- Load with MemtoReg=0 returns the address ----------------
    drive(1'b1, 32'h0000_0020, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    step();
    chk("ld_alu_data",     bus.wb_data,              32'h0000_0020);

    // ---------------- Wrap-around: 0x400 aliases word 0 ----------------
    drive(1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0000, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("wrap_wb_data",    bus.wb_data,              32'hA5A5_A5A5);
    chk("wrap_wb_reg",     {27'd0, bus.wb_reg},      32'd10);

    // ---------------- MemRead & MemWrite together act as a store ----------------
    drive(1'b1, 32'h0000_0008, 32'h0000_0055, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("rw_stall",        {31'd0, bus.stall},       32'd0);
    chk("rw_wb_RegWrite",  {31'd0, bus.wb_RegWrite}, 32'd0);
    drive(1'b1, 32'h0000_0008, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("rw_readback",     bus.wb_data,              32'h0000_0055);

    // ---------------- Reset during LOAD ----------------
    drive(1'b1, 32'h0000_0010, 32'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("rl_in_load",      {31'd0, bus.stall},       32'd1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rl_wb_valid",     {31'd0, bus.wb_valid},    32'd0);
`ifndef MEM_INIT_EN
    chk("rl_stall",        {31'd0, bus.stall},       32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("rl_after_valid",  {31'd0, bus.wb_valid},    32'd0);
    wait_ready();
    drive(1'b1, 32'h0000_0077, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("rl_alu_valid",    {31'd0, bus.wb_valid},    32'd1);
    chk("rl_alu_data",     bus.wb_data,              32'h0000_0077);
    chk("rl_alu_reg",      {27'd0, bus.wb_reg},      32'd2);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
